// File: rtl/ysyx_22051013_icache_nway.sv
// N-way set-associative instruction cache between the IFU and the AXI read master.
// Multi-beat line refill, per-set round-robin replacement, redirect flush and fence.i invalidate.
module ysyx_22051013_icache_nway #(
  parameter int PC_W       = 64,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_BYTES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PC_W-1:0] req_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_inst,
  output logic [PC_W-1:0] rsp_pc,
  input  logic            flush,
  input  logic            fence_i,
  output logic            fence_done,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [PC_W-1:0] mem_req_addr,
  output logic [7:0]      mem_req_len,
  input  logic            mem_rsp_valid,
  input  logic [63:0]     mem_rsp_data,
  input  logic            mem_rsp_last
);

  localparam int BEATS  = LINE_BYTES / 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = PC_W - IDX_W - OFF_W;
  localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_DATA, S_DRAIN, S_FENCE
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [WAYS*SETS-1:0] valid_q, valid_d;
  logic [RR_W-1:0]      rr_q [SETS];
  logic [RR_W-1:0]      rr_d [SETS];
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [RR_W-1:0]      victim_q, victim_d;
  logic                 alive_q, alive_d;

  logic [TAG_W-1:0]     tag_mem  [WAYS][SETS];
  logic [63:0]          data_mem [WAYS][SETS][BEATS];

  logic [IDX_W-1:0]     idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic [WAYS-1:0]      set_valid_s;
  logic [WAYS-1:0]      way_hit_s;
  logic                 hit_s;
  logic [RR_W-1:0]      hit_way_s;
  logic [BEAT_W-1:0]    word_beat_s;
  logic [63:0]          hit_beat_s;
  logic [31:0]          hit_word_s;
  logic [RR_W-1:0]      rr_next_s;
  int                   vslot_s;
  logic                 data_we_s;
  logic                 tag_we_s;

  // Lowest-index invalid way wins; a full set falls back to the round-robin pointer.
  function automatic logic [RR_W-1:0] victim_sel(input logic [WAYS-1:0] vbits,
                                                 input logic [RR_W-1:0] rr);
    logic [RR_W-1:0] way;
    logic            found;
    way   = rr;
    found = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vbits[w]) begin
        way   = RR_W'(w);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return way;
  endfunction

  assign idx_s       = pc_q[OFF_W +: IDX_W];
  assign tag_s       = pc_q[PC_W-1 -: TAG_W];
  assign word_beat_s = BEAT_W'((pc_q >> 3) & PC_W'(BEATS - 1));
  assign vslot_s     = int'(victim_q) * SETS + int'(idx_s);
  assign rr_next_s   = (rr_q[idx_s] == RR_W'(WAYS - 1)) ? '0 : rr_q[idx_s] + 1'b1;

  // Tag compare across all ways of the latched set and hit-word extraction
  always_comb begin
    set_valid_s = '0;
    way_hit_s   = '0;
    hit_way_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid_s[w] = valid_q[w * SETS + int'(idx_s)];
      way_hit_s[w]   = set_valid_s[w] && (tag_mem[w][idx_s] == tag_s);
      hit_way_s      = hit_way_s | (way_hit_s[w] ? RR_W'(w) : '0);
    end
    hit_s      = |way_hit_s;
    hit_beat_s = data_mem[hit_way_s][idx_s][word_beat_s];
    hit_word_s = pc_q[2] ? hit_beat_s[63:32] : hit_beat_s[31:0];
  end

  // Next-state and output logic of the cache controller
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    rr_d          = rr_q;
    beat_d        = beat_q;
    victim_d      = victim_q;
    alive_d       = 1'b1;
    data_we_s     = 1'b0;
    tag_we_s      = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    fence_done    = 1'b0;
    mem_req_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = alive_q & ~flush & ~fence_i;
        if (alive_q && fence_i) begin
          state_d = S_FENCE;
        end else if (req_valid && req_ready) begin
          pc_d    = req_pc;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (hit_s) begin
          rsp_valid = 1'b1;
          if (rsp_ready) begin
            // A consumed hit can accept the next fetch in the same cycle.
            req_ready = ~fence_i;
            if (req_valid && req_ready) begin
              pc_d    = req_pc;
              state_d = S_LOOKUP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_LOOKUP;
          end
        end else begin
          victim_d = victim_sel(set_valid_s, rr_q[idx_s]);
          state_d  = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            beat_d  = '0;
            state_d = S_REFILL_DATA;
          end else begin
            state_d = S_REFILL_REQ;
          end
        end
      end
      S_REFILL_DATA, S_DRAIN: begin
        if (flush && state_q == S_REFILL_DATA) begin
          state_d = S_DRAIN;
        end else begin
          state_d = state_q;
        end
        if (mem_rsp_valid) begin
          data_we_s = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (beat_q == '0) begin
            valid_d[vslot_s] = 1'b0;
          end else begin
            valid_d[vslot_s] = valid_q[vslot_s];
          end
          // The line always installs, even when the fetch itself was flushed.
          if (mem_rsp_last) begin
            valid_d[vslot_s] = 1'b1;
            tag_we_s         = 1'b1;
            rr_d[idx_s]      = rr_next_s;
            beat_d           = '0;
            state_d          = (state_q == S_DRAIN || flush) ? S_IDLE : S_LOOKUP;
          end else begin
            tag_we_s = 1'b0;
          end
        end else begin
          data_we_s = 1'b0;
        end
      end
      S_FENCE: begin
        valid_d    = '0;
        fence_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rsp_inst     = rsp_valid ? hit_word_s : 32'h0;
    rsp_pc       = rsp_valid ? pc_q : '0;
    mem_req_addr = mem_req_valid ? {pc_q[PC_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem_req_len  = mem_req_valid ? 8'(BEATS - 1) : 8'h00;
  end

  // Control state, round-robin pointers and valid bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      valid_q  <= '0;
      beat_q   <= '0;
      victim_q <= '0;
      alive_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      alive_q  <= alive_d;
      rr_q     <= rr_d;
    end
  end

  // Tag and data storage, written only during refill
  always_ff @(posedge clk) begin
    if (data_we_s) begin
      data_mem[victim_q][idx_s][beat_q] <= mem_rsp_data;
    end
    if (tag_we_s) begin
      tag_mem[victim_q][idx_s] <= tag_s;
    end
  end

endmodule

// File: tb/tb_ysyx_22051013_icache_nway.sv
// Self-checking bench for the N-way icache: scoreboard of expected fetch results
// against a behavioural memory slave on the refill port.
module tb_ysyx_22051013_icache_nway;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_pc, rsp_pc;
  logic [31:0] rsp_inst;
  logic        flush, fence_i, fence_done;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_len;
  logic        mem_rsp_valid, mem_rsp_last;
  logic [63:0] mem_rsp_data;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  int          mem_req_cnt = 0;
  int          beats_total = 0;
  bit          hold_ready  = 0;
  int          s_left      = 0;
  int          s_idx       = 0;
  bit          s_hs        = 0;
  logic [63:0] s_addr      = 64'h0;
  logic [63:0] last_addr   = 64'h0;
  logic [7:0]  last_len    = 8'h0;

  ysyx_22051013_icache_nway dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_pc(rsp_pc),
    .flush(flush), .fence_i(fence_i), .fence_done(fence_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mem_beat(input logic [63:0] a);
    logic [31:0] lo, hi;
    if (a == 64'h0000_0000_8000_0000) return 64'h0010_0093_0000_0013;
    if (a == 64'h0000_0000_8000_0008) return 64'h0000_0000_0000_8067;
    lo = a[31:0] ^ 32'h5a5a_1234;
    hi = (a[31:0] + 32'd4) ^ 32'h5a5a_1234;
    return {hi, lo};
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    logic [63:0] b;
    b = mem_beat({pc[63:3], 3'b000});
    return pc[2] ? b[63:32] : b[31:0];
  endfunction

  // Refill slave: decides ready/beats 2 time units after each falling edge.
  always begin
    @(negedge clk);
    #2;
    if (rst !== 1'b1) begin
      s_left = 0; s_idx = 0; s_hs = 0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; mem_rsp_data = 64'h0;
    end else begin
      if (mem_rsp_valid) begin
        s_left--; s_idx++; beats_total++;
      end
      if (s_hs) begin
        mem_req_cnt++; s_addr = last_addr; s_left = int'(last_len) + 1; s_idx = 0;
      end
      mem_rsp_valid = (s_left > 0);
      mem_rsp_last  = (s_left == 1);
      mem_rsp_data  = (s_left > 0) ? mem_beat(s_addr + 64'(8 * s_idx)) : 64'h0;
      mem_req_ready = !hold_ready && (s_left == 0) && mem_req_valid;
      s_hs = mem_req_valid && mem_req_ready;
      if (s_hs) begin
        last_addr = mem_req_addr; last_len = mem_req_len;
      end
    end
  end

  task automatic fetch(input logic [63:0] pc, output bit ok, output int lat,
                       output logic [31:0] inst, output logic [63:0] rpc);
    int n;
    ok = 0; lat = 0; inst = 32'h0; rpc = 64'h0;
    @(negedge clk); req_valid = 1'b1; req_pc = pc; rsp_ready = 1'b1; #1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    sb_q.push_back('{pc: pc, inst: exp_word(pc)});
    @(negedge clk); req_valid = 1'b0; #1; lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); #1; lat++; end
    if (rsp_valid) begin ok = 1; inst = rsp_inst; rpc = rsp_pc; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, mem_req_valid, fence_done} !== 4'b0 || rsp_inst !== 32'h0 ||
        rsp_pc !== 64'h0 || mem_req_addr !== 64'h0 || mem_req_len !== 8'h0) begin
      bad++; $display("FAIL reset_outputs: rdy=%b rv=%b mv=%b fd=%b inst=%h len=%h, want all 0",
                      req_ready, rsp_valid, mem_req_valid, fence_done, rsp_inst, mem_req_len);
    end
    @(negedge clk); rst = 1'b1; #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_release_ready: got %b want 0", req_ready); end
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
  endtask

  task automatic test_cold_miss();
    bit ok; int lat, c0; logic [31:0] inst; logic [63:0] rpc; exp_t e;
    c0 = mem_req_cnt;
    fetch(64'h8000_0004, ok, lat, inst, rpc);
    total++;
    if (!ok || sb_q.size() == 0) begin bad++; $display("FAIL t1_rsp: ok=%0d, want response", ok); end
    else begin
      e = sb_q.pop_front();
      if (inst !== e.inst || rpc !== e.pc || e.inst !== 32'h0010_0093) begin
        bad++; $display("FAIL t1_data: inst=%h pc=%h want inst=%h pc=%h", inst, rpc, e.inst, e.pc);
      end
    end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL t1_latency: got %0d want 5", lat); end
    total++;
    if (mem_req_cnt - c0 !== 1 || last_addr !== 64'h8000_0000 || last_len !== 8'd1) begin
      bad++; $display("FAIL t1_memreq: n=%0d addr=%h len=%0d want 1 80000000 1",
                      mem_req_cnt - c0, last_addr, last_len);
    end
  endtask

  task automatic test_stream();
    int sent, got, c0, first, last_c; exp_t e;
    sent = 0; got = 0; first = -1; last_c = -1; c0 = mem_req_cnt;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      req_valid = (sent < 4); req_pc = 64'h8000_0000 + 64'(4 * sent); rsp_ready = 1'b1;
      #1;
      if (rsp_valid) begin
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL t2_extra_rsp: pc=%h", rsp_pc); end
        else begin
          e = sb_q.pop_front();
          if (rsp_inst !== e.inst || rsp_pc !== e.pc) begin
            bad++; $display("FAIL t2_data: inst=%h pc=%h want %h %h", rsp_inst, rsp_pc, e.inst, e.pc);
          end
        end
        if (first < 0) first = cyc;
        last_c = cyc; got++;
      end
      if (req_valid && req_ready) begin
        sb_q.push_back('{pc: req_pc, inst: exp_word(req_pc)}); sent++;
      end
    end
    req_valid = 1'b0;
    total++;
    if (got !== 4 || last_c - first !== 3) begin
      bad++; $display("FAIL t2_rate: got=%0d span=%0d want 4 rsp over 3 cycles", got, last_c - first);
    end
    total++;
    if (mem_req_cnt !== c0) begin bad++; $display("FAIL t2_no_memreq: got %0d want 0", mem_req_cnt - c0); end
  endtask

  task automatic test_stall();
    exp_t e; int n;
    e = '{pc: 64'h8000_0008, inst: exp_word(64'h8000_0008)};
    @(negedge clk); req_valid = 1'b1; req_pc = 64'h8000_0008; rsp_ready = 1'b0; #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL t2_stall_accept: got %b want 1", req_ready); end
    else sb_q.push_back(e);
    @(negedge clk); req_valid = 1'b0; #1;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (sb_q.size() != 0) e = sb_q.pop_front();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_inst !== e.inst || rsp_pc !== e.pc) begin
        bad++; $display("FAIL t2_stall_hold%0d: v=%b inst=%h pc=%h want 1 %h %h",
                        k, rsp_valid, rsp_inst, rsp_pc, e.inst, e.pc);
      end
      if (k < 3) begin @(negedge clk); #1; end
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    @(negedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL t2_stall_release: got %b want 0", rsp_valid); end
  endtask

  task automatic test_replace();
    logic [63:0] pcs [5];
    bit          miss [5];
    bit ok; int lat, c0; logic [31:0] inst; logic [63:0] rpc; exp_t e;
    pcs  = '{64'h8000_0000, 64'h8000_0400, 64'h8000_0800, 64'h8000_0400, 64'h8000_0000};
    miss = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      c0 = mem_req_cnt;
      fetch(pcs[i], ok, lat, inst, rpc);
      total++;
      if (!ok || sb_q.size() == 0) begin bad++; $display("FAIL t3_rsp%0d: no response", i); end
      else begin
        e = sb_q.pop_front();
        if (inst !== e.inst || rpc !== e.pc) begin
          bad++; $display("FAIL t3_data%0d: inst=%h pc=%h want %h %h", i, inst, rpc, e.inst, e.pc);
        end
      end
      total++;
      if ((mem_req_cnt - c0) !== int'(miss[i]) || lat !== (miss[i] ? 5 : 1)) begin
        bad++; $display("FAIL t3_hitmiss%0d: memreq=%0d lat=%0d want %0d %0d",
                        i, mem_req_cnt - c0, lat, miss[i], miss[i] ? 5 : 1);
      end
    end
  endtask

  task automatic test_fence();
    bit ok; int lat, c0, n; logic [31:0] inst; logic [63:0] rpc; exp_t e;
    @(negedge clk); fence_i = 1'b1; #1;
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_blocked: got %b want 0", req_ready); end
    n = 0;
    while (!fence_done && n < 10) begin @(negedge clk); #1; n++; end
    total++;
    if (fence_done !== 1'b1) begin bad++; $display("FAIL t4_fence_done: got %b want 1", fence_done); end
    @(negedge clk); fence_i = 1'b0; #1;
    total++;
    if (fence_done !== 1'b0) begin bad++; $display("FAIL t4_pulse_width: got %b want 0", fence_done); end
    c0 = mem_req_cnt;
    fetch(64'h8000_0000, ok, lat, inst, rpc);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    total++;
    if (!ok || inst !== e.inst || mem_req_cnt - c0 !== 1 || lat !== 5) begin
      bad++; $display("FAIL t4_refetch: ok=%0d inst=%h memreq=%0d lat=%0d want 1 %h 1 5",
                      ok, inst, mem_req_cnt - c0, lat, e.inst);
    end
  endtask

  task automatic test_flush_refill(input logic [63:0] pc, input int fcyc);
    bit ok, saw; int lat, c0; logic [31:0] inst; logic [63:0] rpc; exp_t e;
    c0 = mem_req_cnt; saw = 0;
    @(negedge clk); req_valid = 1'b1; req_pc = pc; rsp_ready = 1'b1; #1;
    if (req_ready) sb_q.push_back('{pc: pc, inst: exp_word(pc)});
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk); req_valid = 1'b0; flush = (cyc == fcyc); #1;
      if (rsp_valid) saw = 1;
      if (cyc == fcyc + 1 && fcyc == 3) begin
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL t5_drain_busy: got %b want 0", req_ready); end
      end
      if (cyc == 5) begin
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL t5_idle_after_last: got %b want 1", req_ready); end
      end
    end
    flush = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    total++;
    if (saw || mem_req_cnt - c0 !== 1) begin
      bad++; $display("FAIL t5_flushed_rsp: saw=%0d memreq=%0d want 0 1", saw, mem_req_cnt - c0);
    end
    fetch(pc, ok, lat, inst, rpc);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    total++;
    if (!ok || inst !== e.inst || rpc !== pc || lat !== 1 || mem_req_cnt - c0 !== 1) begin
      bad++; $display("FAIL t5_refetch_hit: ok=%0d inst=%h lat=%0d memreq=%0d want 1 %h 1 1",
                      ok, inst, lat, mem_req_cnt - c0, e.inst);
    end
  endtask

  task automatic test_flush_req();
    int c0, b0, n;
    c0 = mem_req_cnt; b0 = beats_total; hold_ready = 1;
    @(negedge clk); req_valid = 1'b1; req_pc = 64'h8000_3000; rsp_ready = 1'b1; #1;
    if (req_ready) sb_q.push_back('{pc: req_pc, inst: exp_word(req_pc)});
    @(negedge clk); req_valid = 1'b0; #1;
    n = 0;
    while (!mem_req_valid && n < 10) begin @(negedge clk); #1; n++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_3000) begin
      bad++; $display("FAIL t5b_req_seen: v=%b addr=%h want 1 80003000", mem_req_valid, mem_req_addr);
    end
    @(negedge clk); flush = 1'b1; #1;
    total++;
    if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL t5b_req_drop: got %b want 0", mem_req_valid); end
    @(negedge clk); flush = 1'b0; hold_ready = 0; #1;
    total++;
    if (req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      bad++; $display("FAIL t5b_idle: rdy=%b mv=%b want 1 0", req_ready, mem_req_valid);
    end
    repeat (4) @(negedge clk);
    #1;
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    total++;
    if (mem_req_cnt !== c0 || beats_total !== b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL t5b_no_refill: memreq=%0d beats=%0d rv=%b want 0 0 0",
                      mem_req_cnt - c0, beats_total - b0, rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat, c0; logic [31:0] inst; logic [63:0] rpc; exp_t e;
    @(negedge clk); req_valid = 1'b1; req_pc = 64'h8000_4000; rsp_ready = 1'b1; #1;
    if (req_ready) sb_q.push_back('{pc: req_pc, inst: exp_word(req_pc)});
    for (int cyc = 1; cyc <= 2; cyc++) begin @(negedge clk); req_valid = 1'b0; #1; end
    @(negedge clk); rst = 1'b0; #1;
    total++;
    if ({req_ready, rsp_valid, mem_req_valid, fence_done} !== 4'b0 || rsp_inst !== 32'h0 ||
        mem_req_addr !== 64'h0 || mem_req_len !== 8'h0) begin
      bad++; $display("FAIL t6_reset_outputs: rdy=%b rv=%b mv=%b fd=%b want all 0",
                      req_ready, rsp_valid, mem_req_valid, fence_done);
    end
    if (sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk); rst = 1'b1;
    c0 = mem_req_cnt;
    fetch(64'h8000_0000, ok, lat, inst, rpc);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    total++;
    if (!ok || inst !== e.inst || lat !== 5 || mem_req_cnt - c0 !== 1) begin
      bad++; $display("FAIL t6_refetch_miss: ok=%0d inst=%h lat=%0d memreq=%0d want 1 %h 5 1",
                      ok, inst, lat, mem_req_cnt - c0, e.inst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_pc = 64'h0; rsp_ready = 1'b0;
    flush = 1'b0; fence_i = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0; mem_rsp_data = 64'h0;
    test_reset();
    test_cold_miss();
    test_stream();
    test_stall();
    test_replace();
    test_fence();
    test_flush_refill(64'h8000_2010, 4);
    test_flush_refill(64'h8000_2020, 3);
    test_flush_req();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_empty: %0d left want 0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
